// File: rtl/pic_read_status_unit_if.sv
// Bus/control bundle between the decoder, the IRR/ISR/IMR block and the read-status unit.
// master = decoder/register side, slave = pic_read_status_unit.
interface pic_read_status_unit_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ID_W  = $clog2(WIDTH)
);
    logic             cs_neg;
    logic             rd_neg;
    logic             a0;
    logic             ocw3_wr;
    logic             ocw3_rr;
    logic             ocw3_ris;
    logic             ocw3_p;
    logic [WIDTH-1:0] imr;
    logic [WIDTH-1:0] isr;
    logic [WIDTH-1:0] irr;
    logic [WIDTH-1:0] read_data;
    logic             read_active_flag;
    logic             poll_ack;
    logic [ID_W-1:0]  poll_id;

    modport master (
        output cs_neg, rd_neg, a0,
        output ocw3_wr, ocw3_rr, ocw3_ris, ocw3_p,
        output imr, isr, irr,
        input  read_data, read_active_flag, poll_ack, poll_id
    );

    modport slave (
        input  cs_neg, rd_neg, a0,
        input  ocw3_wr, ocw3_rr, ocw3_ris, ocw3_p,
        input  imr, isr, irr,
        output read_data, read_active_flag, poll_ack, poll_id
    );
endinterface

// File: rtl/pic_read_status_unit.sv
// PIC read-back unit: IRR/ISR/IMR/poll-word read mux with a data hold for the whole
// read strobe, OCW3 read-select/poll command storage and the poll acknowledge pulse.
module pic_read_status_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ID_W  = $clog2(WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    pic_read_status_unit_if.slave bus
);

    // The poll word packs the "any request" flag in the MSB above the level ID.
    if (WIDTH < 2 || WIDTH < ID_W + 1) begin : g_width_check
        $error("pic_read_status_unit: WIDTH (%0d) must be >= ID_W+1 (%0d) and >= 2",
               WIDTH, ID_W + 1);
    end

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    // Registered state
    state_t           state_q;
    logic [WIDTH-1:0] read_data_q;
    logic             read_active_q;
    logic             poll_ack_q;
    logic [ID_W-1:0]  poll_id_q;
    logic             read_sel_q;
    logic             poll_pending_q;

    // Next-state values
    state_t           state_d;
    logic [WIDTH-1:0] read_data_d;
    logic             read_active_d;
    logic             poll_ack_d;
    logic [ID_W-1:0]  poll_id_d;
    logic             read_sel_d;
    logic             poll_pending_d;

    // Combinational helpers
    logic             rd_req_c;
    logic [WIDTH-1:0] req_c;
    logic             req_any_c;
    logic [ID_W-1:0]  req_id_c;
    logic [WIDTH-1:0] poll_word_c;
    logic [WIDTH-1:0] capture_c;

    assign rd_req_c = !bus.cs_neg && !bus.rd_neg;

    // Unmasked requests, fixed priority with IR0 highest (lowest set bit wins).
    always_comb begin
        req_c     = bus.irr & ~bus.imr;
        req_any_c = |req_c;
        req_id_c  = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (req_c[i]) begin
                req_id_c = ID_W'(i);
            end
        end
    end

    always_comb begin
        poll_word_c             = '0;
        poll_word_c[ID_W-1:0]   = req_id_c;
        poll_word_c[WIDTH-1]    = req_any_c;
    end

    // Read source selection; a pending poll overrides the address bit.
    always_comb begin
        capture_c = bus.irr;
        if (poll_pending_q) begin
            capture_c = poll_word_c;
        end else if (bus.a0) begin
            capture_c = bus.imr;
        end else if (read_sel_q) begin
            capture_c = bus.isr;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            read_data_q    <= '0;
            read_active_q  <= 1'b0;
            poll_ack_q     <= 1'b0;
            poll_id_q      <= '0;
            read_sel_q     <= 1'b0;
            poll_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            read_data_q    <= read_data_d;
            read_active_q  <= read_active_d;
            poll_ack_q     <= poll_ack_d;
            poll_id_q      <= poll_id_d;
            read_sel_q     <= read_sel_d;
            poll_pending_q <= poll_pending_d;
        end
    end

    // Next-state and output logic; S_ACTIVE doubles as the registered read request.
    always_comb begin
        state_d        = state_q;
        read_data_d    = read_data_q;
        poll_ack_d     = 1'b0;
        poll_id_d      = '0;
        read_sel_d     = read_sel_q;
        poll_pending_d = poll_pending_q;

        case (state_q)
            S_IDLE: begin
                if (rd_req_c) begin
                    state_d     = S_ACTIVE;
                    read_data_d = capture_c;
                    if (poll_pending_q) begin
                        poll_pending_d = 1'b0;
                        poll_ack_d     = req_any_c;
                        poll_id_d      = req_any_c ? req_id_c : '0;
                    end
                end
            end
            S_ACTIVE: begin
                if (!rd_req_c) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // OCW3 lands after the capture so a coincident read sees the old settings.
        if (bus.ocw3_wr) begin
            if (bus.ocw3_rr) begin
                read_sel_d = bus.ocw3_ris;
            end
            if (bus.ocw3_p) begin
                poll_pending_d = 1'b1;
            end
        end

        read_active_d = (state_d == S_ACTIVE);
    end

    assign bus.read_data        = read_data_q;
    assign bus.read_active_flag = read_active_q;
    assign bus.poll_ack         = poll_ack_q;
    assign bus.poll_id          = poll_id_q;

endmodule
